// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the byte-writable data memory.
package data_memory_pkg;

  typedef enum logic {INIT, RUN} state_t;

  localparam int BYTE_BITS = 8;

  function automatic int num_bytes(input int data_width);
    return data_width / BYTE_BITS;
  endfunction

endpackage

// File: rtl/data_memory_ram.sv
// Synchronous single-port storage array with per-byte write enables and a
// registered, read-first read port.
module data_memory_ram
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                             clk,
  input  logic                             en,
  input  logic                             we,
  input  logic [num_bytes(DATA_WIDTH)-1:0] be,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  output logic [DATA_WIDTH-1:0]            rdata
);

  localparam int NB = num_bytes(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Callers only present in-range addresses while en is high.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[addr][i*BYTE_BITS +: BYTE_BITS] <= wdata[i*BYTE_BITS +: BYTE_BITS];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_memory_bytewise.sv
// Load/store data memory: init sweep after reset, then a valid/ready request
// port with a two-register response pipeline and range checking.
module data_memory_bytewise
  import data_memory_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 10,
  parameter int                    DEPTH        = 2**ADDR_WIDTH,
  parameter int                    PRESET_ADDR  = 4,
  parameter logic [DATA_WIDTH-1:0] PRESET_VALUE = DATA_WIDTH'(1000)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_we,
  input  logic [num_bytes(DATA_WIDTH)-1:0] req_be,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [DATA_WIDTH-1:0]            req_wdata,
  output logic                             rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic                             rsp_err,
  output logic                             init_busy
);

  localparam int NB = num_bytes(DATA_WIDTH);

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;

  logic                  accept;
  logic                  in_range;

  logic                  ram_en;
  logic                  ram_we;
  logic [NB-1:0]         ram_be;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  pend_valid;
  logic                  pend_we;
  logic                  pend_err;
  logic                  pend_fwd;
  logic [NB-1:0]         fwd_be;
  logic [DATA_WIDTH-1:0] fwd_data;

  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [NB-1:0]         wr_be;
  logic [DATA_WIDTH-1:0] wr_data;

  logic [DATA_WIDTH-1:0] read_word;

  assign accept   = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < (ADDR_WIDTH+1)'(DEPTH);

  // The init sweep owns the array port until RUN; out-of-range requests never touch it.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '0;
    ram_addr  = req_addr;
    ram_wdata = req_wdata;
    if (state == INIT) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_be    = '1;
      ram_addr  = init_cnt;
      ram_wdata = (int'(init_cnt) == PRESET_ADDR) ? PRESET_VALUE : '0;
    end else if (accept && in_range) begin
      ram_en = 1'b1;
      ram_we = req_we;
      ram_be = req_be;
    end
  end

  data_memory_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH     (DEPTH)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .be   (ram_be),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      init_cnt  <= '0;
      req_ready <= 1'b0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ADDR_WIDTH'(DEPTH - 1)) begin
            state     <= RUN;
            req_ready <= 1'b1;
            init_busy <= 1'b0;
          end
        end
        RUN: req_ready <= 1'b1;
        default: state <= INIT;
      endcase
    end
  end

  // First response stage tracks the accepted request alongside the array read,
  // and remembers the previous write so a following read can overlay its bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_we    <= 1'b0;
      pend_err   <= 1'b0;
      pend_fwd   <= 1'b0;
      fwd_be     <= '0;
      fwd_data   <= '0;
      wr_valid   <= 1'b0;
      wr_addr    <= '0;
      wr_be      <= '0;
      wr_data    <= '0;
    end else begin
      pend_valid <= accept;
      pend_we    <= req_we;
      pend_err   <= !in_range;
      pend_fwd   <= accept && !req_we && in_range && wr_valid && (wr_addr == req_addr);
      fwd_be     <= wr_be;
      fwd_data   <= wr_data;
      wr_valid   <= accept && req_we && in_range;
      wr_addr    <= req_addr;
      wr_be      <= req_be;
      wr_data    <= req_wdata;
    end
  end

  always_comb begin
    read_word = ram_rdata;
    for (int i = 0; i < NB; i++) begin
      if (pend_fwd && fwd_be[i]) read_word[i*BYTE_BITS +: BYTE_BITS] = fwd_data[i*BYTE_BITS +: BYTE_BITS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= pend_valid;
      rsp_err   <= pend_valid && pend_err;
      if (pend_valid && !pend_we) rsp_rdata <= pend_err ? '0 : read_word;
    end
  end

endmodule

// File: doc/data_memory_bytewise.md
# data_memory_bytewise

Parametrised single-port data memory for the processor's load/store path. It succeeds the fixed 32-bit/1K-word data memory with four additions:
- configurable width and depth;
- per-byte write enables;
- a valid/ready request interface with a registered, flagged response;
- a hardware init sequencer that clears memory after reset and places one preset word.

It sits between the execute stage's memory-access logic and the storage array.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8
- ADDR_WIDTH, 10, word-address width
- DEPTH, 2**ADDR_WIDTH, implemented words (1..2**ADDR_WIDTH)
- PRESET_ADDR, 4, word written with PRESET_VALUE during init
- PRESET_VALUE, 1000, value written at PRESET_ADDR; every other word is written 0

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = write, 0 = read
- req_be  in  DATA_WIDTH/8  byte enables for writes; ignored on reads
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- rsp_valid  out  1  one-cycle pulse: response for the accepted request
- rsp_rdata  out  DATA_WIDTH  read data; holds its last value otherwise
- rsp_err  out  1  qualified by rsp_valid: address was >= DEPTH
- init_busy  out  1  init sweep in progress

## Operation
- FSM states: INIT, RUN.
- Reset values:
  - state = INIT, init counter = 0
  - req_ready = 0, rsp_valid = 0, rsp_err = 0
  - rsp_rdata = 0, init_busy = 1
- INIT:
  - Writes one word per cycle at the counter: PRESET_VALUE if counter == PRESET_ADDR, else 0, all bytes enabled.
  - Counter increments each cycle. After writing DEPTH-1, the FSM goes to RUN.
  - req_ready = 0; requests are not accepted and need not be held stable.
  - If PRESET_ADDR >= DEPTH, no preset write occurs and the sweep is all zeros.
- RUN:
  - req_ready = 1 every cycle. A request is accepted when req_valid && req_ready.
  - Read, in range: rsp_rdata = mem[req_addr] and rsp_err = 0, both at the response cycle.
  - Write, in range: bytes with req_be[i] = 1 take req_wdata[8i+7:8i]; other bytes are unchanged. rsp_valid pulses as an acknowledge, rsp_err = 0, rsp_rdata is unchanged.
  - Write with req_be = 0: no storage change, acknowledged normally.
  - Out of range (req_addr >= DEPTH), read or write: no array access, rsp_err = 1. rsp_rdata = 0 for reads, unchanged for writes.
  - Back-to-back requests: one per cycle, no bubbles.
  - A read at the same address as the write accepted on the previous cycle returns the newly written data.
- Asynchronous reset asserted at any time, including mid-sweep or with a response pending:
  - Returns to INIT, counter = 0, drops any pending response.
  - Sweep restarts from word 0.
  - Memory contents are not guaranteed until the sweep completes.
- Address width: req_addr is compared as unsigned against DEPTH; no wrap-around.

## Timing
- Init duration: init_busy is high for exactly DEPTH rising edges after rst_n deasserts. req_ready rises in the same cycle init_busy falls.
- Response latency: 1 cycle. A request accepted at edge N gives rsp_valid = 1 after edge N+1, low after N+2 unless another request was accepted.
- rsp_valid, rsp_rdata, rsp_err and req_ready are registered outputs; there is no combinational path from inputs to outputs.
- No backpressure on the response: the consumer must take the response in its valid cycle.

## Structure
- Shared package data_memory_pkg holds:
  - the FSM state typedef (INIT, RUN)
  - a localparam helper for byte count, DATA_WIDTH/8
- One sub-module, data_memory_ram:
  - synchronous single-port array with per-byte write enables
  - registered read, read-first
  - The bypass for the read-after-write case lives in the top level.
- Top level contains the FSM, init counter, range check, request/response registers and the write-to-read forwarding register.

## Test plan
- Reset, then idle with DATA_WIDTH=32, DEPTH=16:
  - init_busy stays high 16 cycles, then req_ready = 1.
  - Reading addresses 0..15 returns 1000 at address 4 and 0 elsewhere, rsp_err = 0.
- Byte-enable write: write 0xAABBCCDD, be=4'b1111 at address 7, then 0x11223344, be=4'b0101 at address 7, then read 7 -> 0xAA22CC44.
- Back-to-back:
  - Write 0x5 at address 3 in cycle N, read 3 in cycle N+1 -> rsp_rdata = 0x5 at N+2.
  - Reads on consecutive cycles give consecutive rsp_valid pulses.
- Out of range with DEPTH=12, ADDR_WIDTH=4:
  - Read address 13 -> rsp_err = 1, rsp_rdata = 0.
  - Write address 13 -> rsp_err = 1. A following read of address 1 (13 mod 12) returns its unmodified value 0.
- Reset mid-operation:
  - Write 0x77 at address 2, then pulse rst_n low mid-sweep of a second init.
  - Sweep restarts at 0. After DEPTH cycles, a read of address 2 -> 0 and a read of address 4 -> 1000.
- Requests during INIT: req_valid held high throughout init -> no rsp_valid until after RUN is entered. The first acceptance is in the cycle init_busy falls.
